// File: rtl/mycpu_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mycpu_axi_pkg
//  Description : Shared AXI read-channel constants and the AR-channel FSM
//                state encoding used by the instruction-fetch bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package mycpu_axi_pkg;

  // AR channel FSM: idle/accepting, or presenting a beat on AR
  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  // Single-beat INCR bursts only
  localparam logic [7:0] c_arlen_single = 8'd0;
  localparam logic [1:0] c_burst_incr   = 2'b01;

  // Anything other than OKAY is treated as a fetch bus error
  localparam logic [1:0] c_resp_okay    = 2'b00;

endpackage : mycpu_axi_pkg
`default_nettype wire

// File: rtl/inst_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : inst_axi_rd_bridge
//  Description : Bridges the IF-stage SRAM-like fetch port onto an AXI read
//                channel. One AR beat per accepted request, up to MAX_OUTST
//                reads in flight, R data returned to IF combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_axi_rd_bridge
  import mycpu_axi_pkg::*;
#(
  parameter logic [3:0]  ARID      = 4'd0,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  // IF-side SRAM-like fetch port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  // Error report
  output logic        fetch_bus_err
);

  // Outstanding limit narrowed to the counter width (legal range 1..3)
  localparam logic [1:0] c_max_outst = MAX_OUTST[1:0];

  ar_state_t   r_state;
  ar_state_t   w_state_next;
  logic [31:0] r_araddr;
  logic [1:0]  r_arsize;
  logic [1:0]  r_outst;

  logic        w_addr_ok;
  logic        w_data_ok;
  logic        w_rready;

  // Accept only reads, only when AR is free and the in-flight budget allows.
  // Reset gating keeps addr_ok low while reset is held even if IF requests.
  assign w_addr_ok = !reset && inst_sram_req && !inst_sram_wr &&
                     (r_state == AR_IDLE) && (r_outst < c_max_outst);

  // R is accepted only when something is in flight; responses arrive in order
  assign w_rready  = (r_outst != 2'd0);
  assign w_data_ok = rvalid && w_rready;

  assign inst_sram_addr_ok = w_addr_ok;
  assign inst_sram_data_ok = w_data_ok;
  assign inst_sram_rdata   = rdata;
  assign rready            = w_rready;
  assign fetch_bus_err     = w_data_ok && (rresp != c_resp_okay);

  assign arid    = ARID;
  assign araddr  = r_araddr;
  assign arlen   = c_arlen_single;
  assign arsize  = {1'b0, r_arsize};
  assign arburst = c_burst_incr;

  // AR FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= AR_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // AR FSM next state and arvalid: one idle cycle between beats by design
  always_comb begin
    w_state_next = r_state;
    arvalid      = 1'b0;
    case (r_state)
      AR_IDLE: begin
        if (w_addr_ok) begin
          w_state_next = AR_SEND;
        end
      end
      AR_SEND: begin
        arvalid = 1'b1;
        if (arready) begin
          w_state_next = AR_IDLE;
        end
      end
      default: begin
        w_state_next = AR_IDLE;
      end
    endcase
  end

  // Capture the request address/size; held stable while AR is presented
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_araddr <= 32'd0;
      r_arsize <= 2'd0;
    end else if (w_addr_ok) begin
      r_araddr <= inst_sram_addr;
      r_arsize <= inst_sram_size;
    end
  end

  // Outstanding-read counter; a same-cycle accept and return cancel out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outst <= 2'd0;
    end else begin
      case ({w_addr_ok, w_data_ok})
        2'b10:   r_outst <= r_outst + 2'd1;
        2'b01:   r_outst <= r_outst - 2'd1;
        default: r_outst <= r_outst;
      endcase
    end
  end

endmodule : inst_axi_rd_bridge
`default_nettype wire

// File: tb/tb_inst_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_axi_rd_bridge
//  Description : Directed self-checking bench for inst_axi_rd_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_axi_rd_bridge;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] if_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  inst_axi_rd_bridge #(.ARID(4'd3), .MAX_OUTST(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (req),
    .inst_sram_wr      (wr),
    .inst_sram_size    (size),
    .inst_sram_addr    (addr),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (if_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arvalid           (arvalid),
    .arready           (arready),
    .rvalid            (rvalid),
    .rready            (rready),
    .rdata             (rdata),
    .rresp             (rresp),
    .fetch_bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; inputs are driven here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h1C00_0000;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    tick(); tick();
    #1;
    n_checks++; if (addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_addr_ok: got %b want 0", addr_ok); end
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
    n_checks++; if (rready !== 1'b0 || data_ok !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_r_side: got rready=%b data_ok=%b err=%b want 0/0/0", rready, data_ok, bus_err); end
    n_checks++; if (araddr !== 32'h0 || arsize !== 3'b000) begin n_fail++; $display("FAIL rst_ar_regs: got araddr=%h arsize=%b want 0/000", araddr, arsize); end
    n_checks++; if (dut.r_outst !== 2'd0) begin n_fail++; $display("FAIL rst_outst: got %0d want 0", dut.r_outst); end
    req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (arid !== 4'd3 || arlen !== 8'd0 || arburst !== 2'b01) begin n_fail++; $display("FAIL ar_consts: got arid=%h arlen=%h arburst=%b want 3/00/01", arid, arlen, arburst); end
    tick();
  endtask

  task automatic test_single_fetch();
    req = 1'b1; addr = 32'h1C00_0000; size = 2'b10;
    #1;
    n_checks++; if (addr_ok !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL single_accept: got addr_ok=%b arvalid=%b want 1/0", addr_ok, arvalid); end
    tick();
    req = 1'b0; arready = 1'b1;
    #1;
    n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0000 || arsize !== 3'b010) begin n_fail++; $display("FAIL single_ar: got arvalid=%b araddr=%h arsize=%b want 1/1c000000/010", arvalid, araddr, arsize); end
    n_checks++; if (addr_ok !== 1'b0 || rready !== 1'b1) begin n_fail++; $display("FAIL single_ar_side: got addr_ok=%b rready=%b want 0/1", addr_ok, rready); end
    tick();
    arready = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL single_ar_drop: got %b want 0", arvalid); end
    tick();
    rvalid = 1'b1; rdata = 32'h0280_0000; rresp = 2'b00;
    #1;
    n_checks++; if (data_ok !== 1'b1 || if_rdata !== 32'h0280_0000 || bus_err !== 1'b0) begin n_fail++; $display("FAIL single_data: got data_ok=%b rdata=%h err=%b want 1/02800000/0", data_ok, if_rdata, bus_err); end
    tick();
    rvalid = 1'b0;
    #1;
    n_checks++; if (dut.r_outst !== 2'd0 || rready !== 1'b0 || data_ok !== 1'b0) begin n_fail++; $display("FAIL single_done: got outst=%0d rready=%b data_ok=%b want 0/0/0", dut.r_outst, rready, data_ok); end
    tick();
  endtask

  task automatic test_backpressure();
    req = 1'b1; addr = 32'h1C00_0040; size = 2'b10;
    #1;
    n_checks++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b want 1", addr_ok); end
    tick();
    arready = 1'b0; addr = 32'h1C00_0080;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0040 || addr_ok !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got arvalid=%b araddr=%h addr_ok=%b want 1/1c000040/0", i, arvalid, araddr, addr_ok); end
      tick();
    end
    arready = 1'b1; req = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0040) begin n_fail++; $display("FAIL bp_release: got arvalid=%b araddr=%h want 1/1c000040", arvalid, araddr); end
    tick();
    arready = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b0 || dut.r_outst !== 2'd1) begin n_fail++; $display("FAIL bp_after: got arvalid=%b outst=%0d want 0/1", arvalid, dut.r_outst); end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (data_ok !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bp_data: got data_ok=%b rdata=%h want 1/deadbeef", data_ok, if_rdata); end
    tick();
    rvalid = 1'b0;
    #1;
    n_checks++; if (dut.r_outst !== 2'd0) begin n_fail++; $display("FAIL bp_done: got outst=%0d want 0", dut.r_outst); end
    tick();
  endtask

  task automatic test_limit();
    int n_acc;
    n_acc = 0;
    req = 1'b1; addr = 32'h1C00_0100; arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (addr_ok === 1'b1) n_acc++;
      tick();
    end
    n_checks++; if (n_acc !== 2) begin n_fail++; $display("FAIL limit_count: got %0d accepts want 2", n_acc); end
    n_checks++; if (dut.r_outst !== 2'd2 || addr_ok !== 1'b0) begin n_fail++; $display("FAIL limit_full: got outst=%0d addr_ok=%b want 2/0", dut.r_outst, addr_ok); end
    rvalid = 1'b1; rdata = 32'h1111_1111;
    #1;
    n_checks++; if (data_ok !== 1'b1 || addr_ok !== 1'b0) begin n_fail++; $display("FAIL limit_first_ret: got data_ok=%b addr_ok=%b want 1/0", data_ok, addr_ok); end
    tick();
    rvalid = 1'b0;
    #1;
    n_checks++; if (addr_ok !== 1'b1 || dut.r_outst !== 2'd1) begin n_fail++; $display("FAIL limit_third: got addr_ok=%b outst=%0d want 1/1", addr_ok, dut.r_outst); end
    tick();
    req = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b1 || dut.r_outst !== 2'd2) begin n_fail++; $display("FAIL limit_third_ar: got arvalid=%b outst=%0d want 1/2", arvalid, dut.r_outst); end
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h2222_2222;
    #1;
    n_checks++; if (data_ok !== 1'b1 || if_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL limit_drain1: got data_ok=%b rdata=%h want 1/22222222", data_ok, if_rdata); end
    tick();
    rdata = 32'h3333_3333;
    #1;
    n_checks++; if (data_ok !== 1'b1 || dut.r_outst !== 2'd1) begin n_fail++; $display("FAIL limit_drain2: got data_ok=%b outst=%0d want 1/1", data_ok, dut.r_outst); end
    tick();
    rvalid = 1'b0;
    #1;
    n_checks++; if (dut.r_outst !== 2'd0 || rready !== 1'b0) begin n_fail++; $display("FAIL limit_empty: got outst=%0d rready=%b want 0/0", dut.r_outst, rready); end
    tick();
  endtask

  task automatic test_simultaneous();
    req = 1'b1; addr = 32'h1C00_0200; arready = 1'b1;
    tick();
    req = 1'b0;
    tick();
    req = 1'b1; addr = 32'h1C00_0204; rvalid = 1'b1; rdata = 32'hAAAA_5555;
    #1;
    n_checks++; if (addr_ok !== 1'b1 || data_ok !== 1'b1 || dut.r_outst !== 2'd1) begin n_fail++; $display("FAIL simul_both: got addr_ok=%b data_ok=%b outst=%0d want 1/1/1", addr_ok, data_ok, dut.r_outst); end
    tick();
    req = 1'b0; rvalid = 1'b0;
    #1;
    n_checks++; if (dut.r_outst !== 2'd1 || arvalid !== 1'b1 || araddr !== 32'h1C00_0204) begin n_fail++; $display("FAIL simul_after: got outst=%0d arvalid=%b araddr=%h want 1/1/1c000204", dut.r_outst, arvalid, araddr); end
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h5555_AAAA;
    #1;
    n_checks++; if (data_ok !== 1'b1 || if_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL simul_ret: got data_ok=%b rdata=%h want 1/5555aaaa", data_ok, if_rdata); end
    tick();
    rvalid = 1'b0;
    #1;
    n_checks++; if (dut.r_outst !== 2'd0) begin n_fail++; $display("FAIL simul_done: got outst=%0d want 0", dut.r_outst); end
    tick();
  endtask

  task automatic test_error();
    req = 1'b1; addr = 32'h1C00_0300; arready = 1'b1;
    tick();
    req = 1'b0;
    tick();
    arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'h0BAD_0BAD;
    #1;
    n_checks++; if (data_ok !== 1'b1 || bus_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got data_ok=%b err=%b want 1/1", data_ok, bus_err); end
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    #1;
    n_checks++; if (bus_err !== 1'b0 || dut.r_outst !== 2'd0) begin n_fail++; $display("FAIL err_clear: got err=%b outst=%0d want 0/0", bus_err, dut.r_outst); end
    tick();
  endtask

  task automatic test_write_rejected();
    req = 1'b1; wr = 1'b1; addr = 32'h1C00_0400;
    #1;
    n_checks++; if (addr_ok !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ok: got %b want 0", addr_ok); end
    tick();
    #1;
    n_checks++; if (arvalid !== 1'b0 || dut.r_outst !== 2'd0) begin n_fail++; $display("FAIL wr_no_ar: got arvalid=%b outst=%0d want 0/0", arvalid, dut.r_outst); end
    req = 1'b0; wr = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    req = 1'b1; addr = 32'h1C00_0500; arready = 1'b1;
    tick();
    tick();
    tick();
    arready = 1'b0; req = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b1 || dut.r_outst !== 2'd2) begin n_fail++; $display("FAIL mid_setup: got arvalid=%b outst=%0d want 1/2", arvalid, dut.r_outst); end
    #1;
    reset = 1'b1; rvalid = 1'b1;
    #1;
    n_checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || dut.r_outst !== 2'd0) begin n_fail++; $display("FAIL mid_async: got arvalid=%b rready=%b outst=%0d want 0/0/0", arvalid, rready, dut.r_outst); end
    n_checks++; if (data_ok !== 1'b0 || araddr !== 32'h0) begin n_fail++; $display("FAIL mid_async_r: got data_ok=%b araddr=%h want 0/0", data_ok, araddr); end
    tick();
    reset = 1'b0; rvalid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_limit();
    test_simultaneous();
    test_error();
    test_write_rejected();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_inst_axi_rd_bridge
`default_nettype wire

// File: doc/inst_axi_rd_bridge.md
INST_AXI_RD_BRIDGE -- requirements
Module: inst_axi_rd_bridge

Interface
REQ-001 SHALL have parameter ARID, default 4'd0: AXI read ID driven on every AR beat.
REQ-002 SHALL have parameter MAX_OUTST, default 2: maximum outstanding reads (legal values 1..3).
REQ-003 SHALL have port clk, input, 1: single clock, all state on posedge.
REQ-004 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port inst_sram_req, input, 1: fetch request from IF.
REQ-006 SHALL have port inst_sram_wr, input, 1: write flag; only 0 is serviced.
REQ-007 SHALL have port inst_sram_size, input, 2: log2 bytes, 2'b10 for fetch.
REQ-008 SHALL have port inst_sram_addr, input, 32: physical fetch address.
REQ-009 SHALL have port inst_sram_addr_ok, output, 1: request accepted this cycle.
REQ-010 SHALL have port inst_sram_data_ok, output, 1: instruction returned this cycle.
REQ-011 SHALL have port inst_sram_rdata, output, 32: returned instruction word.
REQ-012 SHALL have port arid, output, 4: equals ARID.
REQ-013 SHALL have port araddr, output, 32: captured request address.
REQ-014 SHALL have port arlen, output, 8: constant 0, single beat.
REQ-015 SHALL have port arsize, output, 3: {1'b0, captured size}.
REQ-016 SHALL have port arburst, output, 2: constant 2'b01 (INCR).
REQ-017 SHALL have ports arvalid, output, 1 and arready, input, 1: AR handshake.
REQ-018 SHALL have ports rvalid, input, 1 and rready, output, 1: R handshake.
REQ-019 SHALL have port rdata, input, 32: read data beat.
REQ-020 SHALL have port rresp, input, 2: read response code.
REQ-021 SHALL have port fetch_bus_err, output, 1: one-cycle pulse on a non-OKAY response.

Function
REQ-022 SHALL implement AR FSM with states AR_IDLE and AR_SEND.
REQ-023 SHALL assert addr_ok combinationally iff req && !wr && state==AR_IDLE && outst<MAX_OUTST.
REQ-024 SHALL, on addr_ok, capture addr/size and enter AR_SEND next cycle with arvalid=1.
REQ-025 SHALL hold arvalid, araddr and arsize stable in AR_SEND until arready; on arvalid&&arready, return to AR_IDLE next cycle.
REQ-026 SHALL make minimum latency from addr_ok to arvalid exactly 1 cycle, and issue at most one new AR per two cycles.
REQ-027 SHALL keep 2-bit counter outst: +1 on addr_ok, -1 on rvalid&&rready, unchanged when both occur in the same cycle.
REQ-028 SHALL drive rready = (outst != 0); SHALL never decrement below 0 or increment above MAX_OUTST.
REQ-029 SHALL drive data_ok = rvalid && rready and rdata passed through combinationally (zero-cycle R-to-IF latency), in request order.
REQ-030 SHALL pulse fetch_bus_err when data_ok && rresp != 2'b00, and still assert data_ok for that beat.
REQ-031 SHALL never accept wr=1 requests (addr_ok stays 0); IF always drives wr=0.
REQ-032 SHALL ignore a request whose addr_ok lands in the same cycle as rvalid only through the counter rule above; both SHALL complete.

Reset
REQ-033 SHALL, on reset assertion (asynchronous), force state=AR_IDLE, arvalid=0, outst=0, rready=0, addr_ok=0, data_ok=0, fetch_bus_err=0, araddr=0, arsize=0.
REQ-034 SHALL discard in-flight transactions on mid-operation reset; memory side is reset by the same signal.

Structure
REQ-035 SHALL place AR FSM state encoding, AXI burst/resp constants and arlen value in a shared package mycpu_axi_pkg.
REQ-036 SHALL be a single module with no sub-modules.

Verification
REQ-037 SHALL verify single fetch: req at addr 0x1C000000, arready=1 next cycle, rvalid+rdata 0x02800000 two cycles later -> addr_ok 1 cycle, arvalid 1 cycle, data_ok with rdata 0x02800000, outst returns to 0.
REQ-038 SHALL verify backpressure: arready held 0 for 5 cycles -> arvalid/araddr stable all 5 cycles, addr_ok=0 throughout.
REQ-039 SHALL verify limit: MAX_OUTST=2, three back-to-back reqs, no rvalid -> exactly 2 addr_ok, third held until first data_ok.
REQ-040 SHALL verify simultaneity: addr_ok and data_ok in the same cycle with outst=1 -> outst stays 1.
REQ-041 SHALL verify error: rresp=2'b10 -> data_ok=1 and fetch_bus_err=1 for one cycle.
REQ-042 SHALL verify reset mid-flight: reset asserted while arvalid=1, outst=2 -> arvalid, rready and outst become 0 immediately without waiting for clk.
